alu_ctrl_muldiv: RTL
====================

Name: alu_ctrl_muldiv

Overview:
Next-generation EX-stage ALU control for the MIPS datapath. It keeps the full ALUOp/funct to ALUfunc decode and jr detect. It adds a parametrised iterative multiply/divide sequencer with HI/LO registers, covering mult, multu, div, divu, mfhi, mflo, mthi and mtlo. A stall handshake to the hazard unit holds the pipeline while a multi-cycle operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (even, >= 8)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid  in  1  EX-stage instruction valid
ALUOp  in  4  main-control ALU opcode
funct  in  6  R-type function field
rs_val  in  WIDTH  operand A (multiplicand/dividend, mthi/mtlo source)
rt_val  in  WIDTH  operand B (multiplier/divisor)
ALUfunc  out  4  ALU function select (combinational)
jr  out  1  jump-register detect (combinational)
md_stall  out  1  hold IF/ID/EX; multi-cycle op conflicts
md_busy  out  1  sequencer not IDLE
md_done  out  1  one-cycle pulse when HI/LO are written by mult/div
div_zero  out  1  sticky: last div/divu had rt_val==0; cleared on next mult/div issue
hilo_data  out  WIDTH  HI (mfhi) or LO (mflo); 0 otherwise

Behaviour:
- Decode (combinational, no latches): when ALUOp=0010, funct maps as follows.
  - 100001 addu -> 0010; 100011 subu -> 0110; 100100 and -> 0000; 100101 or -> 0001.
  - 100110 xor -> 1001; 000000 sll -> 1010; 000011 sra -> 1011; 000010 srl -> 1100.
  - 101010 slt -> 0111; 101011 sltu -> 1110; 001000 jr -> 0010 with jr=1.
- Non-R ALUOp mapping: 0011 -> 1101; 0000 -> 0010; 0101 -> 0000; 0110 -> 0001; 0111 -> 1001; 0100 -> 0111; 0001 -> 0110; 1001 -> 1110.
- Any unlisted ALUOp or funct -> ALUfunc=1111 (no-op), jr=0.
- md-class functs (ALUOp=0010): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo. All of these drive ALUfunc=1111.
- issue = valid & md-class & ~md_stall.
- md_stall = valid & md-class & md_busy. Non-md instructions never stall.
- State machine IDLE -> MUL or DIV -> FIX -> IDLE.
  - IDLE: on issue of mult/div, capture |rs|, |rt| (magnitudes for signed ops) and the result sign; load count=WIDTH.
  - div/divu with rt_val==0: skip DIV and go directly to FIX.
- MUL: shift-add one bit per cycle; count decrements; leave when count reaches 1 (WIDTH cycles in MUL).
- DIV: restoring divide one quotient bit per cycle; WIDTH cycles.
- FIX: apply two's-complement negation for signed ops (remainder takes the dividend's sign), write HI/LO, pulse md_done, return to IDLE.
- Latency: issue at edge N. md_busy is high in cycles N+1..N+WIDTH+1. HI/LO are valid and md_done is high in cycle N+WIDTH+1. md_busy is 0 at N+WIDTH+2.
- Divide-by-zero: FIX is entered at N+1. Results: HI=rs_val, LO={WIDTH{1}}, div_zero=1.
- mthi/mtlo: write HI/LO from rs_val at the issue edge. Only possible in IDLE, because they stall while busy.
- mfhi/mflo: hilo_data is combinational from the HI/LO registers on issue. It is never driven from partial results.
- Width rules:
  - Products are 2*WIDTH wide: HI=upper half, LO=lower half.
  - Division: LO=quotient, HI=remainder.
  - Signed min/-1 wraps: LO=min, HI=0.
- Reset (async, any state, including mid-operation): state=IDLE, HI=LO=0, count=0, div_zero=0, md_busy=md_done=md_stall=0. Any in-flight result is discarded.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: mult/multu compute the full product with a single-cycle multiplier. The sequencer goes IDLE -> FIX -> IDLE, so md_busy lasts 1 cycle and md_done fires at N+1. Division is unchanged.
- Undefined: iterative WIDTH-cycle multiply as described in Behaviour.

Test Plan:
- Reset and decode: rst_n=0 mid-decode, then sweep all decode entries -> mapping table matches; jr=1 only for funct 001000; unlisted funct -> ALUfunc=1111.
- mult rs=0xFFFFFFFF, rt=0x00000002 -> md_done at issue+33; HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0. divu rs=7, rt=0 -> md_done at issue+1, HI=7, LO=0xFFFFFFFF, div_zero=1.
- mflo issued 5 cycles after mult -> md_stall high until md_done; mflo issues the next cycle with hilo_data=new LO. An addu in the same window never stalls.
- mthi 0x12345678 then mfhi -> hilo_data=0x12345678. rst_n pulsed at issue+10 of div -> immediately IDLE, HI=LO=0, md_busy=0.
- With MULDIV_FAST_MUL_EN defined: mult 3 x 5 -> md_done at issue+1, LO=15, HI=0.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control with an iterative mult/div sequencer and HI/LO registers.
// Build option: MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
//
// state    | meaning
// ST_IDLE  | no mult/div in flight; md-class instructions issue here
// ST_MUL   | shift-add multiply, one multiplier bit per cycle
// ST_DIV   | restoring divide, one quotient bit per cycle
// ST_FIX   | HI/LO hold the signed-corrected result; md_done pulse cycle
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       ALUfunc,
  output logic             jr,
  output logic             md_stall,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hilo_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;

  logic r_type, f_mult, f_multu, f_div, f_divu, f_mfhi, f_mflo, f_mthi, f_mtlo;
  logic f_mul_any, f_div_any, md_class, issue, signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign r_type    = (ALUOp == 4'b0010);
  assign f_mult    = r_type & (funct == 6'b011000);
  assign f_multu   = r_type & (funct == 6'b011001);
  assign f_div     = r_type & (funct == 6'b011010);
  assign f_divu    = r_type & (funct == 6'b011011);
  assign f_mfhi    = r_type & (funct == 6'b010000);
  assign f_mflo    = r_type & (funct == 6'b010010);
  assign f_mthi    = r_type & (funct == 6'b010001);
  assign f_mtlo    = r_type & (funct == 6'b010011);
  assign f_mul_any = f_mult | f_multu;
  assign f_div_any = f_div | f_divu;
  assign md_class  = f_mul_any | f_div_any | f_mfhi | f_mflo | f_mthi | f_mtlo;

  assign md_busy   = (state_q != ST_IDLE);
  assign md_stall  = valid & md_class & md_busy;
  assign issue     = valid & md_class & ~md_busy;
  assign md_done   = done_q;
  assign div_zero  = dz_q;
  assign hilo_data = (issue & f_mfhi) ? hi_q : ((issue & f_mflo) ? lo_q : '0);

  always_comb begin
    ALUfunc = 4'b1111;
    jr      = 1'b0;
    case (ALUOp)
      4'b0010: begin
        case (funct)
          6'b100001: ALUfunc = 4'b0010;
          6'b100011: ALUfunc = 4'b0110;
          6'b100100: ALUfunc = 4'b0000;
          6'b100101: ALUfunc = 4'b0001;
          6'b100110: ALUfunc = 4'b1001;
          6'b000000: ALUfunc = 4'b1010;
          6'b000011: ALUfunc = 4'b1011;
          6'b000010: ALUfunc = 4'b1100;
          6'b101010: ALUfunc = 4'b0111;
          6'b101011: ALUfunc = 4'b1110;
          6'b001000: begin ALUfunc = 4'b0010; jr = 1'b1; end
          default:   ALUfunc = 4'b1111;
        endcase
      end
      4'b0011: ALUfunc = 4'b1101;
      4'b0000: ALUfunc = 4'b0010;
      4'b0101: ALUfunc = 4'b0000;
      4'b0110: ALUfunc = 4'b0001;
      4'b0111: ALUfunc = 4'b1001;
      4'b0100: ALUfunc = 4'b0111;
      4'b0001: ALUfunc = 4'b0110;
      4'b1001: ALUfunc = 4'b1110;
      default: ALUfunc = 4'b1111;
    endcase
  end

  // Signed ops run on magnitudes; signs are re-applied on the final step.
  assign signed_op = f_mult | f_div;
  assign rs_neg    = signed_op & rs_val[WIDTH-1];
  assign rt_neg    = signed_op & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;

  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [WIDTH-1:0]   mul_acc, mul_b, div_acc, div_b, rem_fix, quo_fix;
  logic [2*WIDTH-1:0] mul_prod, mul_fix;
  logic               qbit;

  assign mul_sum  = {1'b0, acc_q} + {1'b0, a_q & {WIDTH{b_q[0]}}};
  assign mul_acc  = mul_sum[WIDTH:1];
  assign mul_b    = {mul_sum[0], b_q[WIDTH-1:1]};
  assign mul_prod = {mul_acc, mul_b};
  assign mul_fix  = neg_q ? -mul_prod : mul_prod;

  assign rem_sh   = {acc_q, b_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, a_q};
  assign qbit     = ~diff[WIDTH];
  assign div_acc  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_b    = {b_q[WIDTH-2:0], qbit};
  assign quo_fix  = neg_q ? -div_b : div_b;
  assign rem_fix  = rneg_q ? -div_acc : div_acc;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod, fast_fix;
  assign fast_prod = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
  assign fast_fix  = (rs_neg ^ rt_neg) ? -fast_prod : fast_prod;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (f_mthi) hi_d = rs_val;
          if (f_mtlo) lo_d = rs_val;
          if (f_mul_any | f_div_any) begin
            dz_d   = 1'b0;
            neg_d  = rs_neg ^ rt_neg;
            rneg_d = rs_neg;
            a_d    = rt_mag;
            b_d    = rs_mag;
            acc_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            if (f_div_any) begin
              if (rt_val == '0) begin
                hi_d    = rs_val;
                lo_d    = '1;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                state_d = ST_FIX;
              end else begin
                state_d = ST_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = fast_fix;
              done_d  = 1'b1;
              state_d = ST_FIX;
`else
              state_d = ST_MUL;
`endif
            end
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc;
        b_d   = mul_b;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = mul_fix;
          done_d  = 1'b1;
          state_d = ST_FIX;
        end
      end
      ST_DIV: begin
        acc_d = div_acc;
        b_d   = div_b;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          done_d  = 1'b1;
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

endmodule
